// File: rtl/fp_pkg.sv
// Shared constants, FSM state type and result-packing helper for the
// single-precision adder back end (normalize/round stage).
//
// Contents:
//   EXP_W, FRAC_W, BIAS, EXP_MAX  IEEE-754 single field geometry
//   QNAN_BIT                      frac bit forced high to quiet a NaN
//   state_t                       {IDLE, NORM, ROUND, DONE}
//   pack_res()                    assembles {sign, exponent field, fraction}
package fp_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int BIAS     = 127;
    localparam int EXP_MAX  = 2 * BIAS + 1;
    localparam int QNAN_BIT = 22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [EXP_W+FRAC_W:0] pack_res(
        input logic              sign,
        input logic [EXP_W-1:0]  exp_field,
        input logic [FRAC_W-1:0] frac
    );
        return {sign, exp_field, frac};
    endfunction

endpackage

// File: rtl/fp_lzc26.sv
// Combinational leading-zero count over the 26-bit {hidden, frac, guard,
// round} field of the adder mantissa.
//
// Ports:
//   field  in   26  bit 25 = hidden ... bit 0 = round
//   count  out  5   number of leading zeros; 26 when field is all zero
module fp_lzc26 (
    input  logic [25:0] field,
    output logic [4:0]  count
);

    // Ascending scan: the highest set bit is the last one written.
    always_comb begin
        count = 5'd26;
        for (int i = 0; i < 26; i++) begin
            if (field[i]) begin
                count = 5'(25 - i);
            end
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// Post-add normalize-and-round stage of the single-precision adder.
// Takes the raw aligned sum, normalizes it with an iterative left shifter
// (at most SHIFT_STEP positions per cycle), rounds to nearest-even and packs
// an IEEE-754 single with overflow/underflow flags.
//
// Build option: FP_DENORM_EN
//   defined   - subnormal results are produced and rounded; out_unf flags
//               an inexact subnormal result
//   undefined - flush-to-zero: a result that cannot be normalized becomes
//               signed zero with out_unf=1
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operand valid
//   in_ready   out  1   block can accept operand (IDLE only)
//   in_sign    in   1   result sign
//   in_exp     in   8   biased exponent of larger operand (0 = subnormal)
//   in_mant    in   27  {carry, hidden, frac[22:0], guard, round}
//   in_sticky  in   1   OR of bits lost during alignment
//   out_valid  out  1   result valid (DONE)
//   out_ready  in   1   downstream accepts result
//   out_res    out  32  packed result
//   out_ovf    out  1   overflow, result is +/-inf
//   out_unf    out  1   underflow
//
// state | meaning
// IDLE  | waiting for an operand, in_ready=1
// NORM  | shifting left until hidden=1 or the exponent bottoms out at 1
// ROUND | round-to-nearest-even, renormalize on carry, pack
// DONE  | result held on out_* until out_ready
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [26:0] in_mant,
    input  logic        in_sticky,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res,
    output logic        out_ovf,
    output logic        out_unf
);

    // Two spare bits so exp+1 on carry and on round-up never wraps.
    localparam int EXP_IW = EXP_W + 2;

    state_t              state, state_nxt;
    logic [25:0]         mant_r, mant_nxt;      // {hidden, frac, guard, round}
    logic                sticky_r, sticky_nxt;
    logic                sign_r, sign_nxt;
    logic [EXP_IW-1:0]   exp_r, exp_nxt;        // effective exponent (>= 1)
    logic [31:0]         res_nxt;
    logic                ovf_nxt, unf_nxt;

    // ---------------- NORM datapath ----------------
    logic [4:0]          lz;
    logic [EXP_IW-1:0]   norm_s;
    logic [25:0]         norm_mant;
    logic [EXP_IW-1:0]   norm_exp;

    fp_lzc26 u_lzc (
        .field (mant_r),
        .count (lz)
    );

    always_comb begin
        norm_s = {{(EXP_IW-5){1'b0}}, lz};
        if (norm_s > EXP_IW'(SHIFT_STEP)) begin
            norm_s = EXP_IW'(SHIFT_STEP);
        end
        // Never take the exponent below 1; what is left over stays subnormal.
        if (norm_s > exp_r - EXP_IW'(1)) begin
            norm_s = exp_r - EXP_IW'(1);
        end
    end

    assign norm_mant = mant_r << norm_s;
    assign norm_exp  = exp_r - norm_s;

    // ---------------- ROUND datapath ----------------
    logic [23:0]         sig24;
    logic                rnd_g, rnd_r, rnd_lsb, rnd_inc;
    logic [24:0]         sum25;
    logic [23:0]         sig_rnd;
    logic [EXP_IW-1:0]   exp_rnd;
    logic [EXP_W-1:0]    exp_field;
    logic                round_ovf, round_unf;

    assign sig24   = mant_r[25:2];
    assign rnd_g   = mant_r[1];
    assign rnd_r   = mant_r[0];
    assign rnd_lsb = mant_r[2];
    assign rnd_inc = rnd_g & (rnd_r | sticky_r | rnd_lsb);
    assign sum25   = {1'b0, sig24} + {24'd0, rnd_inc};
    assign sig_rnd = sum25[24] ? sum25[24:1] : sum25[23:0];
    assign exp_rnd = exp_r + {{(EXP_IW-1){1'b0}}, sum25[24]};

    // A subnormal that rounds up into the hidden bit picks up exponent
    // field 1 here simply because exp_r is already 1.
    assign exp_field = sig_rnd[23] ? exp_rnd[EXP_W-1:0] : '0;
    assign round_ovf = (exp_rnd >= EXP_IW'(EXP_MAX));

`ifdef FP_DENORM_EN
    assign round_unf = ~sig_rnd[23] & (rnd_g | rnd_r | sticky_r);
`else
    assign round_unf = 1'b0;
`endif

    // ---------------- accept-time helpers ----------------
    logic [FRAC_W-1:0]   in_frac, nan_frac;

    assign in_frac = in_mant[24:2];

    always_comb begin
        nan_frac = in_frac;
        if (in_frac != '0) begin
            nan_frac[QNAN_BIT] = 1'b1;
        end
    end

    // ---------------- FSM: next state and datapath ----------------
    always_comb begin
        state_nxt  = state;
        mant_nxt   = mant_r;
        sticky_nxt = sticky_r;
        sign_nxt   = sign_r;
        exp_nxt    = exp_r;
        res_nxt    = out_res;
        ovf_nxt    = out_ovf;
        unf_nxt    = out_unf;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_nxt   = in_sign;
                    mant_nxt   = in_mant[25:0];
                    sticky_nxt = in_sticky;
                    exp_nxt    = (in_exp == '0) ? EXP_IW'(1) : {2'b00, in_exp};
                    res_nxt    = '0;
                    ovf_nxt    = 1'b0;
                    unf_nxt    = 1'b0;
                    if (in_exp == EXP_W'(EXP_MAX)) begin
                        res_nxt   = pack_res(in_sign, EXP_W'(EXP_MAX), nan_frac);
                        state_nxt = DONE;
                    end else if ((in_mant == '0) && !in_sticky) begin
                        res_nxt   = pack_res(in_sign, '0, '0);
                        state_nxt = DONE;
                    end else if (in_mant[26]) begin
                        // Carry: drop one bit; the old round bit joins sticky.
                        mant_nxt   = in_mant[26:1];
                        sticky_nxt = in_sticky | in_mant[0];
                        exp_nxt    = (in_exp == '0) ? EXP_IW'(2)
                                                    : {2'b00, in_exp} + EXP_IW'(1);
                        state_nxt  = ROUND;
                    end else if (in_mant[25]) begin
                        state_nxt = ROUND;
                    end else begin
                        state_nxt = NORM;
                    end
                end
            end

            NORM: begin
                mant_nxt = norm_mant;
                exp_nxt  = norm_exp;
                if (norm_mant[25]) begin
                    state_nxt = ROUND;
                end else if (norm_exp == EXP_IW'(1)) begin
`ifdef FP_DENORM_EN
                    state_nxt = ROUND;
`else
                    res_nxt   = pack_res(sign_r, '0, '0);
                    unf_nxt   = 1'b1;
                    state_nxt = DONE;
`endif
                end
            end

            ROUND: begin
                if (round_ovf) begin
                    res_nxt = pack_res(sign_r, EXP_W'(EXP_MAX), '0);
                end else begin
                    res_nxt = pack_res(sign_r, exp_field, sig_rnd[FRAC_W-1:0]);
                end
                ovf_nxt   = round_ovf;
                unf_nxt   = round_unf;
                state_nxt = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mant_r   <= '0;
            sticky_r <= 1'b0;
            sign_r   <= 1'b0;
            exp_r    <= EXP_IW'(1);
            out_res  <= '0;
            out_ovf  <= 1'b0;
            out_unf  <= 1'b0;
        end else begin
            state    <= state_nxt;
            mant_r   <= mant_nxt;
            sticky_r <= sticky_nxt;
            sign_r   <= sign_nxt;
            exp_r    <= exp_nxt;
            out_res  <= res_nxt;
            out_ovf  <= ovf_nxt;
            out_unf  <= unf_nxt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_fp_norm_round.sv
// Scoreboard bench for fp_norm_round: expected results are queued when an
// operand is driven and compared when the DUT hands a result over.
// A second instance with SHIFT_STEP=1 covers the slow-shifter latency.
module tb_fp_norm_round;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_valid1 = 1'b0;
    logic        in_ready, in_ready1;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [26:0] in_mant = '0;
    logic        in_sticky = 1'b0;
    logic        out_valid, out_valid1;
    logic        out_ready = 1'b1, out_ready1 = 1'b1;
    logic [31:0] out_res, out_res1;
    logic        out_ovf, out_ovf1, out_unf, out_unf1;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] res_q[$];
    logic        ovf_q[$];
    logic        unf_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    fp_norm_round #(.SHIFT_STEP(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_ovf(out_ovf), .out_unf(out_unf)
    );

    fp_norm_round #(.SHIFT_STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_res(out_res1), .out_ovf(out_ovf1), .out_unf(out_unf1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [26:0] mk(input logic c, input logic h, input logic [22:0] f,
                                       input logic g, input logic r);
        return {c, h, f, g, r};
    endfunction

    // Result monitor: pops one expectation per output handshake.
    always @(negedge clk) begin
        if (out_valid) begin
            chk("ready_excl", {31'd0, in_ready}, 32'd0);
        end
        if (out_valid && out_ready) begin
            if (res_q.size() == 0) begin
                chk("sb_extra", res_q.size(), 32'd1);
            end else begin
                string t;
                t = tag_q.pop_front();
                chk({t, "_res"}, out_res, res_q.pop_front());
                chk({t, "_ovf"}, {31'd0, out_ovf}, {31'd0, ovf_q.pop_front()});
                chk({t, "_unf"}, {31'd0, out_unf}, {31'd0, unf_q.pop_front()});
            end
        end
    end

    task automatic accept(input logic s, input logic [7:0] e, input logic [26:0] m,
                          input logic st, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        in_sign = s; in_exp = e; in_mant = m; in_sticky = st; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk({tag, "_acc"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic s, input logic [7:0] e, input logic [26:0] m,
                        input logic st, input logic [31:0] r, input logic ov,
                        input logic un, input int lat, input string tag);
        int cyc;
        res_q.push_back(r);
        ovf_q.push_back(ov);
        unf_q.push_back(un);
        tag_q.push_back(tag);
        accept(s, e, m, st, tag);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_lat"}, cyc, lat);
    endtask

    initial begin
        int cyc;
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_res", out_res, 32'd0);
        chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        chk("rst_out_unf", {31'd0, out_unf}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic 1.0 with downstream stalled for 5 cycles.
        out_ready = 1'b0;
        send(1'b0, 8'd127, mk(0, 1, 23'h0, 0, 0), 1'b0, 32'h3F800000, 0, 0, 2, "basic");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_res", out_res, 32'h3F800000);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        send(1'b0, 8'd127, mk(1, 1, 23'h0, 0, 0), 1'b0, 32'h40400000, 0, 0, 2, "carry");
        send(1'b0, 8'd130, mk(0, 0, 23'h002000, 0, 0), 1'b0, 32'h3C000000, 0, 0, 5, "cancel");
        send(1'b0, 8'd127, mk(0, 1, 23'h7FFFFF, 1, 0), 1'b0, 32'h40000000, 0, 0, 2, "rnd_odd");
        send(1'b0, 8'd127, mk(0, 1, 23'h000002, 1, 0), 1'b0, 32'h3F800002, 0, 0, 2, "rnd_even");
        send(1'b0, 8'd127, mk(0, 1, 23'h0, 1, 0), 1'b1, 32'h3F800001, 0, 0, 2, "rnd_sticky");
        send(1'b1, 8'd100, mk(1, 1, 23'h000001, 0, 1), 1'b0, 32'hB2C00001, 0, 0, 2, "carry_stk");
        send(1'b0, 8'd254, mk(1, 0, 23'h0, 0, 0), 1'b0, 32'h7F800000, 1, 0, 2, "ovf");
        send(1'b0, 8'd255, mk(0, 0, 23'h000001, 0, 0), 1'b0, 32'h7FC00001, 0, 0, 1, "nan");
        send(1'b1, 8'd255, mk(0, 0, 23'h0, 0, 0), 1'b0, 32'hFF800000, 0, 0, 1, "inf");
        send(1'b1, 8'd5, 27'd0, 1'b0, 32'h80000000, 0, 0, 1, "zero");
        send(1'b0, 8'd0, mk(0, 1, 23'h000005, 0, 0), 1'b0, 32'h00800005, 0, 0, 2, "sub_in");
`ifdef FP_DENORM_EN
        send(1'b0, 8'd3, mk(0, 0, 23'h100000, 0, 0), 1'b0, 32'h00400000, 0, 0, 3, "unf");
`else
        send(1'b0, 8'd3, mk(0, 0, 23'h100000, 0, 0), 1'b0, 32'h00000000, 0, 1, 2, "unf");
`endif

        // Slow shifter: ten single-bit NORM cycles.
        @(negedge clk);
        in_sign = 1'b0; in_exp = 8'd130; in_mant = mk(0, 0, 23'h002000, 0, 0);
        in_sticky = 1'b0; in_valid1 = 1'b1;
        cyc = 0;
        while (!in_ready1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        cyc = 1;
        while (!out_valid1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("step1_lat", cyc, 12);
        chk("step1_res", out_res1, 32'h3C000000);
        chk("step1_flags", {30'd0, out_ovf1, out_unf1}, 32'd0);

        // Reset in the middle of NORM abandons the operation.
        accept(1'b0, 8'd130, mk(0, 0, 23'h002000, 0, 0), 1'b0, "rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_res", out_res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send(1'b1, 8'd127, mk(0, 1, 23'h0, 0, 0), 1'b0, 32'hBF800000, 0, 0, 2, "post_rst");

        repeat (3) @(negedge clk);
        chk("sb_empty", res_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
